nexys_starship_monsters: RTL and testbench
==========================================

# nexys_starship_monsters

Parametrised, multi-lane successor to the single bottom-monster controller. It runs one global game FSM (INIT/PLAY/OVER) and NUM_CH independent monster lanes, each with a spawn/kill state machine and a tick-driven survival timer. A lane whose monster survives TIMEOUT ticks ends the game. The block sits between the random-spawn generator and player-shot logic on one side, and the display and gameover logic on the other.

## Interface
- NUM_CH, 4: number of monster lanes (1..8).
- TMR_W, 8: per-lane timer width.
- TIMEOUT, 6: tick count at which a live monster ends the game (1..2^TMR_W-1).
- MAX_ACTIVE, NUM_CH: maximum lanes FULL at once (1..NUM_CH).
- Clk  in  1  system clock; the only clock.
- Reset_n  in  1  **synchronous, active-low reset**.
- timer_tick  in  1  one-cycle tick enable that replaces the old separate timer clock.
- play_flag  in  1  start request, level.
- gameover_ctrl  in  1  external force-gameover, level.
- spawn  in  NUM_CH  per-lane spawn request from the random source.
- kill  in  NUM_CH  per-lane monster-destroyed pulse from the shot logic.
- q_Init, q_Play, q_Over  out  1 each  one-hot global state.
- monster  out  NUM_CH  lane FULL flags.
- gameover  out  1  registered game-over flag.
- active_cnt  out  $clog2(NUM_CH+1)  number of FULL lanes.
- fail_ch  out  $clog2(NUM_CH) (min 1)  lowest lane that reached TIMEOUT; valid while q_Over.
- score  out  16  kill count (only when NS_SCORE_EN is defined).

## Operation
- Global FSM:
  - INIT → PLAY when play_flag=1.
  - PLAY → OVER when any lane timer == TIMEOUT or gameover_ctrl=1.
  - OVER → INIT when play_flag=0.
  - Encodings outside the one-hot set → INIT.
- Lane FSM, EMPTY/FULL, advances only in PLAY:
  - EMPTY → FULL when spawn[i]=1 and the admission check grants. Timer is cleared.
  - FULL → EMPTY when kill[i]=1. Timer is cleared.
  - kill[i] in EMPTY is ignored.
  - spawn[i] in FULL is ignored.
- Admission:
  - Grants are issued in ascending lane index until active_cnt + grants == MAX_ACTIVE.
  - Kills in the same cycle do not free slots until the next cycle.
- Timer:
  - Increments only in FULL, in PLAY, on timer_tick.
  - Saturates at TIMEOUT; never wraps.
  - kill in the same cycle as a tick: the kill wins, so the timer clears and does not increment.
- OVER:
  - Lanes, timers, monster and fail_ch freeze.
  - gameover=1.
- INIT:
  - All lanes are EMPTY, timers are 0, gameover=0.
  - spawn and kill are ignored.
- fail_ch:
  - Captured on the PLAY→OVER edge.
  - If gameover_ctrl alone caused the transition, fail_ch = 0.

## Timing
- Reset (Reset_n=0 at an edge) values:
  - q_Init=1, q_Play=0, q_Over=0.
  - monster=0, gameover=0, active_cnt=0, fail_ch=0, score=0.
  - All lane timers 0.
- Reset mid-game takes effect at the next edge regardless of any other input.
- spawn[i] sampled at edge t → monster[i]=1 after t.
- kill[i] at edge t → monster[i]=0 after t.
- A timer reaching TIMEOUT at edge t → q_Over=1 and gameover=1 after edge t+1 (one-cycle registered decision).
- gameover_ctrl at edge t → q_Over and gameover after t.
- In the same cycle as the PLAY→OVER decision, lane updates still apply. The state is frozen from the following cycle.
- OVER→INIT at edge t:
  - All lanes clear and gameover=0 after t.
  - INIT→PLAY needs play_flag reasserted, at least one cycle later.
- active_cnt is registered and consistent with monster every cycle.

## Configuration
- NS_SCORE_EN defined:
  - score increments by 1 on each accepted kill in PLAY, counting every lane killed in that cycle (multiple kills add together).
  - Saturates at 16'hFFFF.
  - Cleared in INIT.
- NS_SCORE_EN undefined: the score port and counter are absent; all other behaviour is identical.

## Structure
- Package nexys_starship_pkg holds:
  - Global state localparams: INIT=3'b001, PLAY=3'b010, OVER=3'b100.
  - Lane state constants: EMPTY, FULL.
  - Index width helper constants.
- Sub-module nexys_starship_lane holds one lane FSM plus its timer. It is instanced NUM_CH times in a generate loop.
- The top holds the global FSM, admission priority logic, active_cnt, fail_ch capture and the optional score.

## Test plan
1. Reset, then play_flag=1 for one cycle → q_Play=1 next cycle; monster=0, active_cnt=0.
2. NUM_CH=4, MAX_ACTIVE=2, spawn=4'b1111 in PLAY → monster=4'b0011, active_cnt=2. A kill[0] then spawn[2] on the next cycle → monster=4'b0110.
3. Lane 1 FULL with 6 timer_ticks and no kill → gameover=1 and q_Over one cycle after the 6th tick; fail_ch=1. Monster stays frozen.
4. kill[3] and timer_tick in the same cycle with lane 3 timer=5 → lane 3 EMPTY, timer 0, no gameover.
5. In OVER, drop play_flag → INIT, all lanes clear. Assert Reset_n=0 mid-PLAY → all outputs return to reset values at the next edge.
6. NS_SCORE_EN: kill lanes 0 and 2 in one cycle, then lane 1 → score=3. Score resets to 0 on return to INIT.

Source files
------------

// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the multi-lane starship monster controller.
//   - Global game states (one-hot INIT/PLAY/OVER) as localparams and an enum.
//   - Lane states EMPTY/FULL.
//   - Width helpers for lane indices and lane counts.
package nexys_starship_pkg;

  localparam logic [2:0] ST_INIT = 3'b001;
  localparam logic [2:0] ST_PLAY = 3'b010;
  localparam logic [2:0] ST_OVER = 3'b100;

  typedef enum logic [2:0] {
    S_INIT = ST_INIT,
    S_PLAY = ST_PLAY,
    S_OVER = ST_OVER
  } game_state_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_e;

  // Width needed to hold a lane index; a single lane still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width needed to hold a count of 0..n lanes.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/nexys_starship_lane.sv
// One monster lane: EMPTY/FULL state machine plus a saturating survival timer.
// Ports:
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   advance_i      : lane may change state this cycle (game in PLAY)
//   clear_i        : force EMPTY and timer 0 (game entering/staying in INIT)
//   grant_i        : admission granted for a spawn into this lane
//   kill_i         : monster destroyed (only honoured while FULL)
//   tick_i         : timer tick enable
//   full_o         : registered FULL flag
//   full_nxt_o     : FULL flag that will be loaded at the next edge
//   expired_o      : lane is FULL and its timer has reached TIMEOUT
module nexys_starship_lane
  import nexys_starship_pkg::*;
#(
  parameter int TMR_W   = 8,
  parameter int TIMEOUT = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic advance_i,
  input  logic clear_i,
  input  logic grant_i,
  input  logic kill_i,
  input  logic tick_i,
  output logic full_o,
  output logic full_nxt_o,
  output logic expired_o
);

  localparam logic [TMR_W-1:0] TMO = TMR_W'(TIMEOUT);

  lane_state_e      state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  // Next-state and timer logic; a kill always wins over a tick.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    if (clear_i) begin
      state_d = EMPTY;
      tmr_d   = '0;
    end else if (advance_i) begin
      case (state_q)
        EMPTY: begin
          if (grant_i) begin
            state_d = FULL;
            tmr_d   = '0;
          end else begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (kill_i) begin
            state_d = EMPTY;
            tmr_d   = '0;
          end else if (tick_i && (tmr_q < TMO)) begin
            tmr_d = tmr_q + {{(TMR_W-1){1'b0}}, 1'b1};
          end else begin
            tmr_d = tmr_q;
          end
        end
        default: begin
          state_d = EMPTY;
          tmr_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Lane state and timer registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  assign full_o     = (state_q == FULL);
  assign full_nxt_o = (state_d == FULL);
  assign expired_o  = (state_q == FULL) && (tmr_q == TMO);

endmodule

// File: rtl/nexys_starship_monsters.sv
// Multi-lane monster controller: global INIT/PLAY/OVER game FSM, NUM_CH lanes
// with survival timers, ascending-priority spawn admission, fail lane capture.
// Optional feature macro: NS_SCORE_EN adds a saturating 16-bit kill score.
// Ports:
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   timer_tick_i         : one-cycle timer tick enable
//   play_flag_i          : start request (level)
//   gameover_ctrl_i      : external force-gameover (level)
//   spawn_i, kill_i      : per-lane spawn request / kill pulse
//   q_init_o/q_play_o/q_over_o : one-hot global state
//   monster_o            : lane FULL flags
//   gameover_o           : registered game-over flag
//   active_cnt_o         : number of FULL lanes
//   fail_ch_o            : lowest lane that timed out (valid in OVER)
//   score_o              : kill count (NS_SCORE_EN only)
module nexys_starship_monsters
  import nexys_starship_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int TMR_W      = 8,
  parameter int TIMEOUT    = 6,
  parameter int MAX_ACTIVE = NUM_CH,
  localparam int CNT_W     = cnt_w(NUM_CH),
  localparam int FCH_W     = idx_w(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              timer_tick_i,
  input  logic              play_flag_i,
  input  logic              gameover_ctrl_i,
  input  logic [NUM_CH-1:0] spawn_i,
  input  logic [NUM_CH-1:0] kill_i,
  output logic              q_init_o,
  output logic              q_play_o,
  output logic              q_over_o,
  output logic [NUM_CH-1:0] monster_o,
  output logic              gameover_o,
  output logic [CNT_W-1:0]  active_cnt_o,
  output logic [FCH_W-1:0]  fail_ch_o
`ifdef NS_SCORE_EN
  ,
  output logic [15:0]       score_o
`endif
);

  game_state_e       state_q, state_d;
  logic              gameover_q, gameover_d;
  logic [CNT_W-1:0]  active_cnt_q, active_cnt_d;
  logic [FCH_W-1:0]  fail_ch_q, fail_ch_d, fail_idx_s;
  logic [NUM_CH-1:0] full_s, full_nxt_s, expired_s, grant_s;
  logic              advance_s, clear_s, any_exp_s;

  assign any_exp_s = |expired_s;
  assign advance_s = (state_q == S_PLAY);
  // Lanes are cleared on every edge that leaves the game in INIT.
  assign clear_s   = (state_d == S_INIT);

  // Global game FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  state_d = play_flag_i ? S_PLAY : S_INIT;
      S_PLAY:  state_d = (any_exp_s || gameover_ctrl_i) ? S_OVER : S_PLAY;
      S_OVER:  state_d = play_flag_i ? S_OVER : S_INIT;
      default: state_d = S_INIT;
    endcase
  end

  // Admission: grant spawns in ascending lane order while slots remain.
  // Slots come from the registered count, so same-cycle kills free nothing.
  always_comb begin
    int slots;
    grant_s = '0;
    slots   = int'(active_cnt_q);
    for (int i = 0; i < NUM_CH; i++) begin
      grant_s[i] = spawn_i[i] && !full_s[i] && (slots < MAX_ACTIVE);
      slots      = slots + int'(grant_s[i]);
    end
  end

  // Lowest expired lane index (scan from the top so the lowest wins).
  always_comb begin
    fail_idx_s = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      fail_idx_s = expired_s[i] ? FCH_W'(i) : fail_idx_s;
    end
  end

  // Derived next values: lane count, game-over flag, fail lane capture.
  always_comb begin
    active_cnt_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      active_cnt_d = active_cnt_d + CNT_W'(full_nxt_s[i]);
    end
    gameover_d = (state_d == S_OVER);
    if ((state_q == S_PLAY) && (state_d == S_OVER)) begin
      fail_ch_d = any_exp_s ? fail_idx_s : '0;
    end else begin
      fail_ch_d = fail_ch_q;
    end
  end

  // Global registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_INIT;
      gameover_q   <= 1'b0;
      active_cnt_q <= '0;
      fail_ch_q    <= '0;
    end else begin
      state_q      <= state_d;
      gameover_q   <= gameover_d;
      active_cnt_q <= active_cnt_d;
      fail_ch_q    <= fail_ch_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    nexys_starship_lane #(
      .TMR_W  (TMR_W),
      .TIMEOUT(TIMEOUT)
    ) u_lane (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .advance_i (advance_s),
      .clear_i   (clear_s),
      .grant_i   (grant_s[g]),
      .kill_i    (kill_i[g]),
      .tick_i    (timer_tick_i),
      .full_o    (full_s[g]),
      .full_nxt_o(full_nxt_s[g]),
      .expired_o (expired_s[g])
    );
  end

`ifdef NS_SCORE_EN
  logic [15:0]      score_q, score_d;
  logic [CNT_W-1:0] kill_cnt_s;
  logic [16:0]      score_sum_s;

  // Score: add every accepted kill this cycle, saturate, clear in INIT.
  always_comb begin
    kill_cnt_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      kill_cnt_s = kill_cnt_s + CNT_W'(kill_i[i] & full_s[i]);
    end
    score_sum_s = {1'b0, score_q} + 17'(kill_cnt_s);
    if (clear_s) begin
      score_d = 16'h0000;
    end else if (advance_s) begin
      score_d = score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
    end else begin
      score_d = score_q;
    end
  end

  // Score register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      score_q <= 16'h0000;
    end else begin
      score_q <= score_d;
    end
  end

  assign score_o = score_q;
`endif

  assign q_init_o     = (state_q == S_INIT);
  assign q_play_o     = (state_q == S_PLAY);
  assign q_over_o     = (state_q == S_OVER);
  assign monster_o    = full_s;
  assign gameover_o   = gameover_q;
  assign active_cnt_o = active_cnt_q;
  assign fail_ch_o    = fail_ch_q;

endmodule

// File: tb/tb_nexys_starship_monsters.sv
// Self-checking bench for nexys_starship_monsters (NUM_CH=4, TIMEOUT=6,
// MAX_ACTIVE=2). A game-level model updated on each rising edge is compared
// against every output on each falling edge; directed steps add literal pins.
module tb_nexys_starship_monsters;

  localparam int NUM_CH     = 4;
  localparam int TMR_W      = 8;
  localparam int TIMEOUT    = 6;
  localparam int MAX_ACTIVE = 2;

  localparam int M_INIT = 0;
  localparam int M_PLAY = 1;
  localparam int M_OVER = 2;

  logic       clk = 1'b0;
  logic       rst_n, play, goc, tick;
  logic [3:0] spawn, kill;
  logic       q_init, q_play, q_over, gameover;
  logic [3:0] monster;
  logic [2:0] active_cnt;
  logic [1:0] fail_ch;
`ifdef NS_SCORE_EN
  logic [15:0] score;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model state
  int m_st = M_INIT;
  bit m_full[NUM_CH];
  int m_tmr[NUM_CH];
  int m_fail = 0;
  int m_score = 0;

  nexys_starship_monsters #(
    .NUM_CH    (NUM_CH),
    .TMR_W     (TMR_W),
    .TIMEOUT   (TIMEOUT),
    .MAX_ACTIVE(MAX_ACTIVE)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .timer_tick_i   (tick),
    .play_flag_i    (play),
    .gameover_ctrl_i(goc),
    .spawn_i        (spawn),
    .kill_i         (kill),
    .q_init_o       (q_init),
    .q_play_o       (q_play),
    .q_over_o       (q_over),
    .monster_o      (monster),
    .gameover_o     (gameover),
    .active_cnt_o   (active_cnt),
    .fail_ch_o      (fail_ch)
`ifdef NS_SCORE_EN
    ,
    .score_o        (score)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NUM_CH; i++) n += int'(m_full[i]);
    return n;
  endfunction

  function automatic logic [3:0] m_pack();
    logic [3:0] v = 4'b0000;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_full[i];
    return v;
  endfunction

  task automatic m_clear_lanes();
    for (int i = 0; i < NUM_CH; i++) begin
      m_full[i] = 1'b0;
      m_tmr[i]  = 0;
    end
  endtask

  // Game rules applied once per rising edge from the sampled inputs.
  task automatic model_step();
    int exp_lane;
    int free;
    if (!rst_n) begin
      m_st = M_INIT;
      m_clear_lanes();
      m_fail  = 0;
      m_score = 0;
    end else if (m_st == M_INIT) begin
      if (play) m_st = M_PLAY;
    end else if (m_st == M_PLAY) begin
      exp_lane = -1;
      for (int i = NUM_CH - 1; i >= 0; i--)
        if (m_full[i] && m_tmr[i] == TIMEOUT) exp_lane = i;
      free = MAX_ACTIVE - m_count();
      for (int i = 0; i < NUM_CH; i++) begin
        if (m_full[i]) begin
          if (kill[i]) begin
            m_full[i] = 1'b0;
            m_tmr[i]  = 0;
            if (m_score < 65535) m_score++;
          end else if (tick && m_tmr[i] < TIMEOUT) begin
            m_tmr[i]++;
          end
        end else if (spawn[i] && free > 0) begin
          m_full[i] = 1'b1;
          m_tmr[i]  = 0;
          free--;
        end
      end
      if (exp_lane >= 0 || goc) begin
        m_st   = M_OVER;
        m_fail = (exp_lane >= 0) ? exp_lane : 0;
      end
    end else begin
      if (!play) begin
        m_st = M_INIT;
        m_clear_lanes();
        m_score = 0;
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("q_init", 32'(q_init), 32'(m_st == M_INIT));
      chk("q_play", 32'(q_play), 32'(m_st == M_PLAY));
      chk("q_over", 32'(q_over), 32'(m_st == M_OVER));
      chk("gameover", 32'(gameover), 32'(m_st == M_OVER));
      chk("monster", 32'(monster), 32'(m_pack()));
      chk("active_cnt", 32'(active_cnt), 32'(m_count()));
      if (m_st == M_OVER) chk("fail_ch", 32'(fail_ch), 32'(m_fail));
`ifdef NS_SCORE_EN
      chk("score", 32'(score), 32'(m_score));
`endif
    end
  end

  task automatic drive(input logic r, input logic p, input logic g, input logic t,
                       input logic [3:0] sp, input logic [3:0] k);
    rst_n = r; play = p; goc = g; tick = t; spawn = sp; kill = k;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst q_init", 32'(q_init), 32'd1);
    chk("rst q_play", 32'(q_play), 32'd0);
    chk("rst monster", 32'(monster), 32'd0);
    chk("rst active", 32'(active_cnt), 32'd0);
    chk("rst fail_ch", 32'(fail_ch), 32'd0);

    // Start, admission limit, kill then spawn.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000); cyc();
    chk("start q_play", 32'(q_play), 32'd1);
    chk("start monster", 32'(monster), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000); cyc();
    chk("admit monster", 32'(monster), 32'h3);
    chk("admit active", 32'(active_cnt), 32'd2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001); cyc();
    chk("kill0 monster", 32'(monster), 32'h2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000); cyc();
    chk("spawn2 monster", 32'(monster), 32'h6);

    // Six ticks: lanes 1 and 2 reach TIMEOUT, decision one cycle later.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000); cyc();
    end
    chk("tmo still play", 32'(q_play), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000); cyc();
    chk("tmo q_over", 32'(q_over), 32'd1);
    chk("tmo gameover", 32'(gameover), 32'd1);
    chk("tmo fail_ch", 32'(fail_ch), 32'd1);
`ifdef NS_SCORE_EN
    chk("game1 score", 32'(score), 32'd1);
`endif
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111); cyc();
    chk("over frozen", 32'(monster), 32'h6);
    chk("over fail held", 32'(fail_ch), 32'd1);

    // Back to INIT, then a second game.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000); cyc();
    chk("init q_init", 32'(q_init), 32'd1);
    chk("init monster", 32'(monster), 32'd0);
    chk("init gameover", 32'(gameover), 32'd0);
`ifdef NS_SCORE_EN
    chk("init score", 32'(score), 32'd0);
`endif
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000); cyc();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0101, 4'b0000); cyc();
    chk("g2 monster", 32'(monster), 32'h5);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0101); cyc();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000); cyc();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010); cyc();
`ifdef NS_SCORE_EN
    chk("multi-kill score", 32'(score), 32'd3);
`endif

    // Kill and tick together on lane 3 at timer 5.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b0000); cyc();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000); cyc();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1000); cyc();
    chk("kill+tick monster", 32'(monster), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000); cyc();
    end
    chk("kill+tick no over", 32'(gameover), 32'd0);

    // Forced game over reports lane 0.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000); cyc();
    chk("force q_over", 32'(q_over), 32'd1);
    chk("force fail_ch", 32'(fail_ch), 32'd0);

    // Reset in the middle of a game.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000); cyc();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000); cyc();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000); cyc();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, 4'b0000); cyc();
    chk("midrst q_init", 32'(q_init), 32'd1);
    chk("midrst monster", 32'(monster), 32'd0);
    chk("midrst active", 32'(active_cnt), 32'd0);
    chk("midrst gameover", 32'(gameover), 32'd0);

    // Randomized play against the model.
    for (int n = 0; n < 4000; n++) begin
      drive(($urandom_range(0, 499) != 0),
            ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 59) == 0),
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)),
            {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)});
      cyc();
    end

    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    cyc();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
